note_sequencer: RTL and testbench
=================================

# note_sequencer

Record-and-playback scheduler between the keyboard-decode stage and the note datapath. It captures up to DEPTH (note, octave) pairs as the user keys them in. On a playback request it replays them in order, presenting each note to the datapath for a fixed duration followed by a fixed silent gap. It owns the ld_note sequencing so the datapath and audio path only ever see one note at a time.

## Interface
Parameters:
- DEPTH, 16: buffer capacity in notes; power of two, 2..64.
- NOTE_TICKS, 12_500_000: clk cycles each note is sounded (0.25 s at 50 MHz); must be ≥ 1.
- GAP_TICKS, 2_500_000: silent clk cycles after each note; must be ≥ 1.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-low; sampled on rising clk.
- clear  in  1  single-cycle pulse; empties the buffer and aborts playback.
- record  in  1  single-cycle pulse; append note_in/octave_in.
- play  in  1  single-cycle pulse; start playback from entry 0.
- note_in  in  4  note code; 4'hF = rest.
- octave_in  in  2  octave.
- note_out  out  4  note presented to the datapath.
- octave_out  out  2  octave presented to the datapath.
- ld_note  out  1  one-cycle strobe when note_out/octave_out change to a new entry.
- note_valid  out  1  high while a non-rest note should sound.
- busy  out  1  high while playback is in progress.
- full  out  1  count == DEPTH.
- count  out  log2(DEPTH)+1  number of stored notes.

## Operation
- All outputs are registered. Reset (reset=0 at an edge) values: state IDLE, count 0, note_out 0, octave_out 0, ld_note 0, note_valid 0, busy 0, full 0. Reset does not need to zero buffer contents; entries at index ≥ count are never read.
- States:
  - IDLE: accepts record and play.
  - PLAY: tick counter runs 0..NOTE_TICKS-1.
  - GAP: tick counter runs 0..GAP_TICKS-1.
- Priority within a cycle: reset > clear > play > record. Only one action is taken per cycle.
- record in IDLE with count < DEPTH: buf[count] ← {octave_in, note_in}, count +1. When count == DEPTH, record is silently dropped and count holds. Record outside IDLE is ignored.
- play in IDLE with count == 0: no effect. Otherwise: index ← 0, note_out/octave_out ← buf[0], ld_note pulse, busy ← 1, go to PLAY. play while busy is ignored; it does not restart playback.
- PLAY: note_valid = 1 unless the current note is 4'hF, in which case it is 0. When the tick counter reaches NOTE_TICKS-1: note_valid ← 0, go to GAP.
- GAP: at terminal count:
  - if index+1 < count: index +1, load the next entry, pulse ld_note, go to PLAY.
  - otherwise: busy ← 0, go to IDLE. note_out/octave_out keep the last entry.
- clear in any state:
  - next edge: count 0, state IDLE, busy 0, note_valid 0, note_out 0, octave_out 0, tick counter 0.
  - no ld_note pulse.
- Buffer holds its contents across playback; play may be repeated any number of times.
- Tick counter width is ceil(log2(max(NOTE_TICKS, GAP_TICKS))); it never wraps past its terminal value.

## Timing
- play accepted at edge t: at t+1 the state is PLAY, ld_note=1 (for that cycle only), note_valid=1 and busy=1.
- Each entry: note_valid high for exactly NOTE_TICKS cycles, then low for exactly GAP_TICKS cycles. The next ld_note follows the last GAP cycle with no dead cycle.
- For N stored notes, busy is high for exactly N·(NOTE_TICKS+GAP_TICKS) cycles.
- record at edge t: count and full update at t+1. A play in the cycle immediately after a record sees the new entry.
- full is asserted in the same cycle that count becomes DEPTH.
- reset or clear mid-note: note_valid drops on the next edge; there is no partial-gap behaviour.

## Test plan
Parameters: DEPTH=4, NOTE_TICKS=4, GAP_TICKS=2.
- Reset: hold reset=0 for 2 cycles, then release → all outputs 0, count 0, busy 0.
- Record and play three notes:
  - record (1,0), (5,2), (9,3); then play.
  - ld_note pulses at cycles 1, 7 and 13 after play.
  - note_out sequence is 1, 5, 9; note_valid pattern is 4 high / 2 low, repeated three times.
  - busy is high for 18 cycles; final state IDLE with count 3.
- Overflow: record 5 notes → count 4 and full=1; the 5th record is ignored; playback shows only 4 notes.
- Rest and collisions:
  - a stored 4'hF gives ld_note=1 with note_valid=0 for its slot.
  - play with count 0 → busy stays 0.
  - play while busy → no restart; the ld_note spacing is unchanged.
- Clear mid-playback: clear during the 2nd note's PLAY → next cycle count 0, busy 0, note_valid 0, note_out 0. A following play has no effect.
- Simultaneous events:
  - record and clear in the same cycle → count 0.
  - play and record in the same cycle in IDLE → play wins; count is unchanged.
  - reset mid-GAP → IDLE with count 0.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer
//
// Record-and-playback scheduler that sits between the keyboard-decode stage
// and the note datapath. Notes keyed in by the user are captured into a small
// buffer; on request they are replayed in order, each one presented for a
// fixed sounding time followed by a fixed silent gap. This block is the only
// source of ld_note, so downstream logic only ever sees one note at a time.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   clear       pulse: empty the buffer and abort any playback
//   record      pulse: append note_in/octave_in while idle
//   play        pulse: replay the buffer from entry 0 while idle
//   note_in     note code to record (4'hF is a rest)
//   octave_in   octave to record
//   note_out    note presented to the datapath
//   octave_out  octave presented to the datapath
//   ld_note     one-cycle strobe whenever a new entry is presented
//   note_valid  high while a non-rest note should sound
//   busy        high for the whole playback
//   full        buffer holds DEPTH notes
//   count       number of stored notes
module note_sequencer #(
    parameter int DEPTH      = 16,
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 2_500_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     record,
    input  logic                     play,
    input  logic [3:0]               note_in,
    input  logic [1:0]               octave_in,
    output logic [3:0]               note_out,
    output logic [1:0]               octave_out,
    output logic                     ld_note,
    output logic                     note_valid,
    output logic                     busy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [3:0]    REST      = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [5:0]      note_buf [DEPTH];
    logic [AW-1:0]   index, index_n, index_next;
    logic [CW-1:0]   index_plus;
    logic [TW-1:0]   tick, tick_n;
    logic [CW-1:0]   count_n;
    logic [3:0]      note_n;
    logic [1:0]      octave_n;
    logic            ld_n, valid_n, busy_n, full_n;
    logic            wr_en;

    assign index_next = index + 1'b1;
    assign index_plus = {1'b0, index} + CW'(1);

    // Next-state and next-output logic. Everything defaults to holding its
    // current value with ld_note low, then clear, play and record are
    // considered in priority order so at most one action happens per cycle.
    // A play in IDLE claims the cycle even if a record arrives alongside it.
    always_comb begin
        state_n  = state;
        count_n  = count;
        index_n  = index;
        tick_n   = tick;
        note_n   = note_out;
        octave_n = octave_out;
        ld_n     = 1'b0;
        valid_n  = note_valid;
        busy_n   = busy;
        wr_en    = 1'b0;

        if (clear) begin
            state_n  = IDLE;
            count_n  = '0;
            index_n  = '0;
            tick_n   = '0;
            note_n   = '0;
            octave_n = '0;
            valid_n  = 1'b0;
            busy_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (play) begin
                        if (count != '0) begin
                            index_n  = '0;
                            tick_n   = '0;
                            note_n   = note_buf[0][3:0];
                            octave_n = note_buf[0][5:4];
                            ld_n     = 1'b1;
                            valid_n  = (note_buf[0][3:0] != REST);
                            busy_n   = 1'b1;
                            state_n  = PLAY;
                        end
                    end else if (record && (count < DEPTH_C)) begin
                        wr_en   = 1'b1;
                        count_n = count + CW'(1);
                    end
                end
                PLAY: begin
                    if (tick == NOTE_LAST) begin
                        tick_n  = '0;
                        valid_n = 1'b0;
                        state_n = GAP;
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
                GAP: begin
                    if (tick == GAP_LAST) begin
                        tick_n = '0;
                        if (index_plus < count) begin
                            index_n  = index_next;
                            note_n   = note_buf[index_next][3:0];
                            octave_n = note_buf[index_next][5:4];
                            ld_n     = 1'b1;
                            valid_n  = (note_buf[index_next][3:0] != REST);
                            state_n  = PLAY;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    tick_n  = '0;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                end
            endcase
        end

        full_n = (count_n == DEPTH_C);
    end

    // State and output registers. Every output comes straight from a flop;
    // full is computed from the next count so it rises together with count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            index      <= '0;
            tick       <= '0;
            note_out   <= '0;
            octave_out <= '0;
            ld_note    <= 1'b0;
            note_valid <= 1'b0;
            busy       <= 1'b0;
            full       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            index      <= index_n;
            tick       <= tick_n;
            note_out   <= note_n;
            octave_out <= octave_n;
            ld_note    <= ld_n;
            note_valid <= valid_n;
            busy       <= busy_n;
            full       <= full_n;
        end
    end

    // Note storage. Contents are deliberately left alone by reset and clear:
    // only entries below count are ever read, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            note_buf[count[AW-1:0]] <= {octave_in, note_in};
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
//
// Directed bench for note_sequencer with DEPTH=4, NOTE_TICKS=4, GAP_TICKS=2.
// A small buffer model predicts what each playback should present; the
// expected (note, octave, valid, cycle) of every ld_note is queued when play
// is driven and popped by a monitor when the strobe appears.
module tb_note_sequencer;

    localparam int DEPTH = 4;
    localparam int NT    = 4;
    localparam int GT    = 2;
    localparam int P     = NT + GT;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       record;
    logic       play;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic       ld_note;
    logic       note_valid;
    logic       busy;
    logic       full;
    logic [2:0] count;

    typedef struct {
        logic [3:0] note;
        logic [1:0] oct;
        logic       valid;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    exp_t       popped;
    logic [3:0] m_note [DEPTH];
    logic [1:0] m_oct  [DEPTH];
    int         m_count = 0;
    int         cyc     = 0;
    int         errors  = 0;
    int         checks  = 0;

    note_sequencer #(
        .DEPTH      (DEPTH),
        .NOTE_TICKS (NT),
        .GAP_TICKS  (GT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .record     (record),
        .play       (play),
        .note_in    (note_in),
        .octave_in  (octave_in),
        .note_out   (note_out),
        .octave_out (octave_out),
        .ld_note    (ld_note),
        .note_valid (note_valid),
        .busy       (busy),
        .full       (full),
        .count      (count)
    );

    // Free-running clock and an edge counter used to timestamp ld_note.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Every ld_note must match the next queued expectation, including the
    // exact cycle it appears on; a strobe with nothing queued is an error.
    always @(negedge clk) begin
        if (ld_note === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("ld_unexpected", {31'b0, ld_note}, 32'd0);
            end else begin
                popped = sb.pop_front();
                check_output("ld_cycle", cyc, popped.cyc);
                check_output("ld_note_out", {28'b0, note_out}, {28'b0, popped.note});
                check_output("ld_octave_out", {30'b0, octave_out}, {30'b0, popped.oct});
                check_output("ld_note_valid", {31'b0, note_valid}, {31'b0, popped.valid});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic c, input logic r, input logic p,
                                  input logic [3:0] n, input logic [1:0] o);
        clear     = c;
        record    = r;
        play      = p;
        note_in   = n;
        octave_in = o;
        step();
        clear  = 1'b0;
        record = 1'b0;
        play   = 1'b0;
    endtask

    task automatic check_idle_empty(input string tag);
        check_output({tag, "_count"}, {29'b0, count}, 32'd0);
        check_output({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check_output({tag, "_valid"}, {31'b0, note_valid}, 32'd0);
        check_output({tag, "_note"}, {28'b0, note_out}, 32'd0);
        check_output({tag, "_octave"}, {30'b0, octave_out}, 32'd0);
        check_output({tag, "_full"}, {31'b0, full}, 32'd0);
        check_output({tag, "_ld"}, {31'b0, ld_note}, 32'd0);
    endtask

    task automatic do_record(input logic [3:0] n, input logic [1:0] o);
        if (m_count < DEPTH) begin
            m_note[m_count] = n;
            m_oct[m_count]  = o;
            m_count = m_count + 1;
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, n, o);
        check_output("rec_count", {29'b0, count}, m_count);
        check_output("rec_full", {31'b0, full}, (m_count == DEPTH) ? 32'd1 : 32'd0);
    endtask

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < m_count; k++) begin
            e.note  = m_note[k];
            e.oct   = m_oct[k];
            e.valid = (m_note[k] != 4'hF);
            e.cyc   = cyc + 1 + k * P;
            sb.push_back(e);
        end
    endtask

    task automatic do_play();
        push_expected();
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'h0, 2'h0);
    endtask

    // Walk a playback cycle by cycle from the cycle after play was accepted.
    // stop_at below n*P leaves playback in progress for the caller;
    // busy_play_at injects a play pulse while busy.
    task automatic run_playback(input int n, input int stop_at, input int busy_play_at);
        int slot;
        int pos;
        for (int j = 0; j < stop_at; j++) begin
            slot = j / P;
            pos  = j % P;
            check_output($sformatf("pb_busy_%0d", j), {31'b0, busy}, 32'd1);
            check_output($sformatf("pb_valid_%0d", j), {31'b0, note_valid},
                         ((pos < NT) && (m_note[slot] != 4'hF)) ? 32'd1 : 32'd0);
            check_output($sformatf("pb_note_%0d", j), {28'b0, note_out}, {28'b0, m_note[slot]});
            check_output($sformatf("pb_oct_%0d", j), {30'b0, octave_out}, {30'b0, m_oct[slot]});
            if (j == busy_play_at) play = 1'b1;
            step();
            play = 1'b0;
        end
        if (stop_at == n * P) begin
            check_output("pb_end_busy", {31'b0, busy}, 32'd0);
            check_output("pb_end_valid", {31'b0, note_valid}, 32'd0);
            check_output("pb_end_count", {29'b0, count}, m_count);
            check_output("pb_end_note", {28'b0, note_out}, {28'b0, m_note[n-1]});
            check_output("pb_sb_drained", sb.size(), 32'd0);
        end
    endtask

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        record    = 1'b0;
        play      = 1'b0;
        note_in   = 4'h0;
        octave_in = 2'h0;
        step();
        step();
        reset = 1'b1;
        $display("[TB] reset released");
        check_idle_empty("reset");

        $display("[TB] record three notes and play");
        do_record(4'd1, 2'd0);
        do_record(4'd5, 2'd2);
        do_record(4'd9, 2'd3);
        do_play();
        run_playback(3, 3 * P, -1);

        $display("[TB] replay the same buffer");
        do_play();
        run_playback(3, 3 * P, -1);

        $display("[TB] overflow, rest note, play while busy");
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'h0, 2'h0);
        m_count = 0;
        check_idle_empty("clear1");
        do_record(4'd2, 2'd1);
        do_record(4'hF, 2'd0);
        do_record(4'd7, 2'd1);
        do_record(4'd3, 2'd2);
        do_record(4'd4, 2'd3);
        do_play();
        run_playback(4, 4 * P, 9);

        $display("[TB] play with empty buffer");
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'h0, 2'h0);
        m_count = 0;
        check_idle_empty("clear2");
        do_play();
        check_output("empty_play_busy", {31'b0, busy}, 32'd0);
        step();
        check_idle_empty("empty_play");

        $display("[TB] clear during second note");
        do_record(4'd1, 2'd0);
        do_record(4'd5, 2'd2);
        do_record(4'd9, 2'd3);
        do_play();
        run_playback(3, 7, -1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'h0, 2'h0);
        m_count = 0;
        sb.delete();
        check_idle_empty("midclear");
        do_play();
        check_output("midclear_play_busy", {31'b0, busy}, 32'd0);
        step();
        step();
        check_output("midclear_play_busy2", {31'b0, busy}, 32'd0);

        $display("[TB] record and clear together");
        do_record(4'd8, 2'd1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd3, 2'd3);
        m_count = 0;
        check_output("recclr_count", {29'b0, count}, 32'd0);

        $display("[TB] play and record together");
        do_record(4'd10, 2'd2);
        do_record(4'd11, 2'd1);
        push_expected();
        apply_stimulus(1'b0, 1'b1, 1'b1, 4'd6, 2'd1);
        check_output("playrec_count", {29'b0, count}, m_count);
        run_playback(2, 2 * P, -1);

        $display("[TB] reset during gap");
        do_play();
        run_playback(2, NT, -1);
        check_output("gap_valid", {31'b0, note_valid}, 32'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        m_count = 0;
        sb.delete();
        check_idle_empty("gapreset");
        step();
        check_idle_empty("gapreset_after");

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
